hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Controller FSM state encoding
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        BFLUSH = 2'd2
    } state_t;

    // ALU operand source select encodings
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Saturation value for the event counters
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Load-use hazard detection: an in-flight load in ID/EX writes a register
    // that the instruction in IF/ID is about to read.
    function automatic logic load_use(
        input logic       ex_mem_read,
        input logic       ex_reg_write,
        input logic [5:0] ex_rd,
        input logic       id_use_rs,
        input logic [5:0] id_rs,
        input logic       id_use_rt,
        input logic [5:0] id_rt
    );
        return ex_mem_read && ex_reg_write &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding source select for one ALU operand.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the pipeline register fields.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [5:0] src,
    input  logic [5:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [5:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd
);

    // The youngest producer (EX/MEM) wins over the older one (MEM/WB); register 0 is not special
    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && (mem_rd == src)) begin
            fwd = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd == src)) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, operand forwarding.
// Latency: stall/flush/forward outputs are combinational from state and inputs; counters update 1 cycle later.
// Backpressure: pc_stall/ifid_stall hold upstream stages; a taken branch always overrides a stall.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 1,   // total stall cycles per load-use hazard, 1..7
    parameter int BR_FLUSH   = 2    // total flush cycles per taken branch, 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_rs,
    input  logic [5:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [5:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [5:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [5:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic        br_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    // The first stall/flush cycle happens in RUN, so the counter holds the remaining ones
    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] BF_RELOAD = 3'(BR_FLUSH - 1);
    localparam bit         LS_MULTI  = (LOAD_STALL > 1);
    localparam bit         BF_MULTI  = (BR_FLUSH > 1);

    state_t     state;
    logic [2:0] cnt;
    logic       hit;
    logic       stall;
    logic       flush;

    assign hit = load_use(ex_mem_read, ex_reg_write, ex_rd,
                          id_use_rs, id_rs, id_use_rt, id_rt);

    // Stall and flush decisions; branch beats stall, and reset silences both
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        flush = 1'b1;
                    end else if (hit) begin
                        stall = 1'b1;
                    end
                end
                LSTALL: begin
                    if (br_taken) begin
                        flush = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                BFLUSH: begin
                    flush = 1'b1;
                end
                default: begin
                    stall = 1'b0;
                    flush = 1'b0;
                end
            endcase
        end
    end

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = flush;
    assign idex_flush  = flush;

    // Sequencing FSM: counts out the remaining stall or flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        if (BF_MULTI) begin
                            state <= BFLUSH;
                            cnt   <= BF_RELOAD;
                        end
                    end else if (hit && LS_MULTI) begin
                        state <= LSTALL;
                        cnt   <= LS_RELOAD;
                    end
                end
                LSTALL: begin
                    if (br_taken) begin
                        // Branch abandons the stall and starts a fresh flush sequence
                        if (BF_MULTI) begin
                            state <= BFLUSH;
                            cnt   <= BF_RELOAD;
                        end else begin
                            state <= RUN;
                            cnt   <= 3'd0;
                        end
                    end else if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                BFLUSH: begin
                    if (br_taken) begin
                        // A second taken branch restarts the flush window
                        if (BF_MULTI) begin
                            cnt <= BF_RELOAD;
                        end else begin
                            state <= RUN;
                            cnt   <= 3'd0;
                        end
                    end else if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    fwd_sel u_fwd_a (
        .src           (id_rs),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src           (id_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LOAD_STALL=3/BR_FLUSH=2 and 1/1) on shared inputs.
// Latency: outputs sampled at negedge, counters one edge after the event.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int LS0 = 3;
    localparam int BF0 = 2;
    localparam int LS1 = 1;
    localparam int BF1 = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs, id_use_rt, ex_reg_write, ex_mem_read;
    logic        mem_reg_write, wb_reg_write, br_taken;

    logic [1:0]  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush;
    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic [15:0] stall_cnt [2];
    logic [15:0] flush_cnt [2];

    hazard_ctrl #(.LOAD_STALL(LS0), .BR_FLUSH(BF0)) u0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .br_taken(br_taken),
        .pc_stall(pc_stall[0]), .ifid_stall(ifid_stall[0]), .idex_bubble(idex_bubble[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
        .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
    );

    hazard_ctrl #(.LOAD_STALL(LS1), .BR_FLUSH(BF1)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .br_taken(br_taken),
        .pc_stall(pc_stall[1]), .ifid_stall(ifid_stall[1]), .idex_bubble(idex_bubble[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
        .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // All five control outputs of instance i against expected stall/flush levels
    task automatic chk_ctl(input string nm, input int i, input bit s, input bit f);
        chk($sformatf("%s u%0d pc_stall", nm, i),    16'(pc_stall[i]),    16'(s));
        chk($sformatf("%s u%0d ifid_stall", nm, i),  16'(ifid_stall[i]),  16'(s));
        chk($sformatf("%s u%0d idex_bubble", nm, i), 16'(idex_bubble[i]), 16'(s));
        chk($sformatf("%s u%0d ifid_flush", nm, i),  16'(ifid_flush[i]),  16'(f));
        chk($sformatf("%s u%0d idex_flush", nm, i),  16'(idex_flush[i]),  16'(f));
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks how many stall / flush cycles are still owed, not FSM states.
    int  ls_p [2] = '{LS0, LS1};
    int  bf_p [2] = '{BF0, BF1};
    int  rem_s [2];
    int  rem_f [2];
    int  m_sc [2];
    int  m_fc [2];
    bit  m_stall [2];
    bit  m_flush [2];

    function automatic bit ref_hit();
        return ex_mem_read && ex_reg_write &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [5:0] s);
        if (mem_reg_write && mem_rd == s) return 2'b01;
        if (wb_reg_write && wb_rd == s)   return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        for (int i = 0; i < 2; i++) begin
            m_stall[i] = 1'b0;
            m_flush[i] = 1'b0;
            if (!rst) begin
                if (br_taken)          m_flush[i] = 1'b1;
                else if (rem_f[i] > 0) m_flush[i] = 1'b1;
                else if (rem_s[i] > 0) m_stall[i] = 1'b1;
                else if (ref_hit())    m_stall[i] = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem_s[i] = 0; rem_f[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if (m_stall[i] && m_sc[i] < 65535) m_sc[i]++;
                if (m_flush[i] && m_fc[i] < 65535) m_fc[i]++;
                if (br_taken) begin
                    rem_f[i] = bf_p[i] - 1;
                    rem_s[i] = 0;
                end else if (rem_f[i] > 0) rem_f[i]--;
                else if (rem_s[i] > 0)     rem_s[i]--;
                else if (ref_hit())        rem_s[i] = ls_p[i] - 1;
            end
        end
    endtask

    // One model-checked cycle; inputs are already applied
    task automatic rcycle(input bit do_chk);
        @(negedge clk);
        model_eval();
        if (do_chk) begin
            for (int i = 0; i < 2; i++) begin
                chk_ctl("rand", i, m_stall[i], m_flush[i]);
                chk($sformatf("rand u%0d stall_cnt", i), stall_cnt[i], 16'(m_sc[i]));
                chk($sformatf("rand u%0d flush_cnt", i), flush_cnt[i], 16'(m_fc[i]));
                chk($sformatf("rand u%0d fwd_a", i), 16'(fwd_a[i]), 16'(ref_fwd(id_rs)));
                chk($sformatf("rand u%0d fwd_b", i), 16'(fwd_b[i]), 16'(ref_fwd(id_rt)));
            end
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // One hand-checked cycle with expected levels for both instances
    task automatic hcyc(input string nm, input bit s0, input bit f0, input bit s1, input bit f1);
        @(negedge clk);
        chk_ctl(nm, 0, s0, f0);
        chk_ctl(nm, 1, s1, f1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        br_taken = 0;
    endtask

    task automatic set_hit();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 6'd5;
        id_use_rs = 1; id_rs = 6'd5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_commit();
        #1;
        rst = 1'b0;
    endtask

    // Forwarding vectors: inputs and hand-derived operand selects
    typedef struct {
        logic [5:0] rs, rt, mrd;
        logic       mwe;
        logic [5:0] wrd;
        logic       wwe;
        logic [1:0] ea, eb;
    } fv_t;

    fv_t tv [8];

    initial begin
        tv[0] = '{6'd7,  6'd8,  6'd7,  1'b1, 6'd7,  1'b1, 2'b01, 2'b00};
        tv[1] = '{6'd7,  6'd8,  6'd7,  1'b0, 6'd7,  1'b1, 2'b10, 2'b00};
        tv[2] = '{6'd7,  6'd7,  6'd7,  1'b0, 6'd7,  1'b0, 2'b00, 2'b00};
        tv[3] = '{6'd0,  6'd0,  6'd0,  1'b1, 6'd0,  1'b1, 2'b01, 2'b01};
        tv[4] = '{6'd3,  6'd9,  6'd9,  1'b1, 6'd3,  1'b1, 2'b10, 2'b01};
        tv[5] = '{6'd63, 6'd62, 6'd62, 1'b1, 6'd63, 1'b0, 2'b00, 2'b01};
        tv[6] = '{6'd12, 6'd12, 6'd13, 1'b1, 6'd12, 1'b1, 2'b10, 2'b10};
        tv[7] = '{6'd5,  6'd6,  6'd5,  1'b1, 6'd6,  1'b1, 2'b01, 2'b10};

        clear_inputs();
        rst = 1'b1;

        // Reset holds outputs low even with a branch and a hazard present
        set_hit();
        br_taken = 1;
        hcyc("reset_gate", 0, 0, 0, 0);
        chk("reset u0 stall_cnt", stall_cnt[0], 16'd0);
        chk("reset u1 flush_cnt", flush_cnt[1], 16'd0);
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Forwarding table
        for (int k = 0; k < 8; k++) begin
            id_rs = tv[k].rs; id_rt = tv[k].rt;
            mem_rd = tv[k].mrd; mem_reg_write = tv[k].mwe;
            wb_rd = tv[k].wrd; wb_reg_write = tv[k].wwe;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("fwd_a vec%0d u%0d", k, i), 16'(fwd_a[i]), 16'(tv[k].ea));
                chk($sformatf("fwd_b vec%0d u%0d", k, i), 16'(fwd_b[i]), 16'(tv[k].eb));
            end
            @(posedge clk); #1;
        end
        clear_inputs();

        // Load-use: hit present one cycle only
        set_hit();
        hcyc("lu_c1", 1, 0, 1, 0);
        clear_inputs();
        hcyc("lu_c2", 1, 0, 0, 0);
        hcyc("lu_c3", 1, 0, 0, 0);
        hcyc("lu_c4", 0, 0, 0, 0);
        chk("lu u0 stall_cnt", stall_cnt[0], 16'd3);
        chk("lu u1 stall_cnt", stall_cnt[1], 16'd1);

        // Single-cycle taken branch
        br_taken = 1;
        hcyc("br_c1", 0, 1, 0, 1);
        br_taken = 0;
        hcyc("br_c2", 0, 1, 0, 0);
        hcyc("br_c3", 0, 0, 0, 0);
        chk("br u0 flush_cnt", flush_cnt[0], 16'd2);
        chk("br u1 flush_cnt", flush_cnt[1], 16'd1);

        // Branch lands in the second cycle of a stall
        set_hit();
        hcyc("bs_c1", 1, 0, 1, 0);
        clear_inputs();
        br_taken = 1;
        hcyc("bs_c2", 0, 1, 0, 1);
        br_taken = 0;
        hcyc("bs_c3", 0, 1, 0, 0);
        hcyc("bs_c4", 0, 0, 0, 0);
        chk("bs u0 stall_cnt", stall_cnt[0], 16'd4);
        chk("bs u0 flush_cnt", flush_cnt[0], 16'd4);

        // Reset in the middle of a stall aborts it
        set_hit();
        hcyc("rs_c1", 1, 0, 1, 0);
        clear_inputs();
        rst = 1'b1;
        hcyc("rs_c2", 0, 0, 0, 0);
        rst = 1'b0;
        hcyc("rs_c3", 0, 0, 0, 0);
        chk("rs u0 stall_cnt", stall_cnt[0], 16'd0);
        chk("rs u0 flush_cnt", flush_cnt[0], 16'd0);

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(63) == 0);
            br_taken     = ($urandom_range(7) == 0);
            ex_mem_read  = ($urandom_range(2) == 0);
            ex_reg_write = ($urandom_range(3) != 0);
            ex_rd        = 6'($urandom_range(3));
            id_rs        = 6'($urandom_range(3));
            id_rt        = 6'($urandom_range(3));
            id_use_rs    = 1'($urandom_range(1));
            id_use_rt    = 1'($urandom_range(1));
            mem_rd       = 6'($urandom_range(3));
            wb_rd        = 6'($urandom_range(3));
            mem_reg_write = 1'($urandom_range(1));
            wb_reg_write  = 1'($urandom_range(1));
            rcycle(1'b1);
        end

        // Continuous hazard drives the stall counters into saturation
        clear_inputs();
        do_reset();
        set_hit();
        for (int k = 0; k < 65540; k++) begin
            rcycle((k % 8192 == 0) || (k > 65530));
        end
        chk("sat u0 stall_cnt", stall_cnt[0], 16'hFFFF);
        chk("sat u1 stall_cnt", stall_cnt[1], 16'hFFFF);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
